// File: rtl/vga_grid_cursor_if.sv
// Signal bundle between the VGA timing source, the buttons and the grid/cursor pixel stage.
// The slave side is the pixel stage; the master side drives timing/buttons and observes the result.
interface vga_grid_cursor_if;
  logic [9:0] posx;
  logic [9:0] posy;
  logic       h_sync;
  logic       v_sync;
  logic       blank_n;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_sel;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       h_sync_o;
  logic       v_sync_o;
  logic       blank_n_o;
  logic       sync_n_o;
  logic [1:0] cursor_row;
  logic [1:0] cursor_col;
  logic [8:0] marks;

  modport slave (
    input  posx, posy, h_sync, v_sync, blank_n,
    input  btn_up, btn_down, btn_left, btn_right, btn_sel,
    output vga_r, vga_g, vga_b, h_sync_o, v_sync_o, blank_n_o, sync_n_o,
    output cursor_row, cursor_col, marks
  );

  modport master (
    output posx, posy, h_sync, v_sync, blank_n,
    output btn_up, btn_down, btn_left, btn_right, btn_sel,
    input  vga_r, vga_g, vga_b, h_sync_o, v_sync_o, blank_n_o, sync_n_o,
    input  cursor_row, cursor_col, marks
  );
endinterface

// File: rtl/vga_grid_cursor.sv
// 3x3 grid overlay with a button-driven cursor and per-cell marks, two-clock pixel pipeline.
// Button events are debounced by one shared FSM and applied only at the start of a frame.
module vga_grid_cursor #(
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int GRID_X0 = 80,
  parameter int CELL_PX = 160,
  parameter int LINE_W  = 4,
  parameter int DEB_CYC = 250000
) (
  input logic            clk,
  input logic            rst_n,
  vga_grid_cursor_if.slave vga
);
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [9:0] HS   = 10'(H_START);
  localparam logic [9:0] HE   = 10'(H_START + 640);
  localparam logic [9:0] VS   = 10'(V_START);
  localparam logic [9:0] VE   = 10'(V_START + 480);
  localparam logic [9:0] GX0  = 10'(GRID_X0);
  localparam logic [9:0] C1   = 10'(CELL_PX);
  localparam logic [9:0] C2   = 10'(2 * CELL_PX);
  localparam logic [9:0] GW   = 10'(3 * CELL_PX);
  localparam logic [9:0] LW   = 10'(LINE_W);
  localparam logic [9:0] EDGE = 10'(3 * CELL_PX - LINE_W);

  typedef enum logic [1:0] {IDLE, DEB, HOLD} state_t;
  typedef enum logic [2:0] {EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, EV_SEL} ev_t;

  function automatic ev_t pick(input logic [4:0] b);
    if (b[0])      return EV_UP;
    else if (b[1]) return EV_DOWN;
    else if (b[2]) return EV_LEFT;
    else if (b[3]) return EV_RIGHT;
    else           return EV_SEL;
  endfunction

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return {2'b00, r} * 4'd3 + {2'b00, c};
  endfunction

  logic [4:0]       btn_raw, btn_s1, btn_s2;
  state_t           state;
  ev_t              ev_lat, pend_ev;
  logic             pend_vld;
  logic [CNT_W-1:0] cnt;
  logic             vs_prev, fs;
  logic [1:0]       row, col;
  logic [8:0]       marks;
  logic [3:0]       cur_idx;

  assign btn_raw = {vga.btn_sel, vga.btn_right, vga.btn_left, vga.btn_down, vga.btn_up};
  assign fs      = vs_prev & ~vga.v_sync;
  assign cur_idx = cell_idx(row, col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      vs_prev <= 1'b1;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      vs_prev <= vga.v_sync;
    end
  end

  // A completion on a frame-start cycle lands in the slot being drained and waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ev_lat   <= EV_UP;
      cnt      <= '0;
      pend_vld <= 1'b0;
      pend_ev  <= EV_UP;
      row      <= 2'd1;
      col      <= 2'd1;
      marks    <= '0;
    end else begin
      if (fs) begin
        if (pend_vld) begin
          case (pend_ev)
            EV_UP:    row <= (row == 2'd0) ? 2'd2 : row - 2'd1;
            EV_DOWN:  row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
            EV_LEFT:  col <= (col == 2'd0) ? 2'd2 : col - 2'd1;
            EV_RIGHT: col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
            EV_SEL:   marks[cur_idx] <= ~marks[cur_idx];
            default:  ;
          endcase
        end
        pend_vld <= 1'b0;
      end
      case (state)
        IDLE: if (|btn_s2) begin
          ev_lat <= pick(btn_s2);
          cnt    <= '0;
          state  <= DEB;
        end
        DEB: begin
          if (!btn_s2[ev_lat]) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= HOLD;
            if (!pend_vld || fs) begin
              pend_vld <= 1'b1;
              pend_ev  <= ev_lat;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD:    if (~|btn_s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: position relative to the active window
  logic [9:0] ax_p1, ay_p1;
  logic       act_p1, hs_p1, vs_p1, bl_p1;

  always_ff @(posedge clk) begin
    ax_p1 <= vga.posx - HS;
    ay_p1 <= vga.posy - VS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_p1 <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
      bl_p1  <= 1'b0;
    end else begin
      act_p1 <= (vga.posx >= HS) && (vga.posx < HE) && (vga.posy >= VS) && (vga.posy < VE);
      hs_p1  <= vga.h_sync;
      vs_p1  <= vga.v_sync;
      bl_p1  <= vga.blank_n;
    end
  end

  // Stage 2: cell lookup by comparison and colour selection
  logic [9:0]  gx, ox, oy;
  logic [1:0]  c2, r2;
  logic        in_grid, line, is_cur, is_mk;
  logic [23:0] rgb_nx, rgb_p2;
  logic        hs_p2, vs_p2, bl_p2, sn_p2;

  always_comb begin
    gx      = ax_p1 - GX0;
    in_grid = act_p1 && bl_p1 && (gx < GW);
    c2      = (gx < C1) ? 2'd0 : (gx < C2) ? 2'd1 : 2'd2;
    r2      = (ay_p1 < C1) ? 2'd0 : (ay_p1 < C2) ? 2'd1 : 2'd2;
    ox      = gx - ((c2 == 2'd0) ? 10'd0 : (c2 == 2'd1) ? C1 : C2);
    oy      = ay_p1 - ((r2 == 2'd0) ? 10'd0 : (r2 == 2'd1) ? C1 : C2);
    line    = (ox < LW) || (oy < LW) || (gx >= EDGE) || (ay_p1 >= EDGE);
    is_cur  = (r2 == row) && (c2 == col);
    is_mk   = marks[cell_idx(r2, c2)];
    rgb_nx  = 24'h000000;
    if (in_grid) begin
      if (line)                 rgb_nx = 24'hFFFFFF;
      else if (is_cur && is_mk) rgb_nx = 24'hFF00FF;
      else if (is_cur)          rgb_nx = 24'h0000FF;
      else if (is_mk)           rgb_nx = 24'hFF0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p2 <= '0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      bl_p2  <= 1'b0;
      sn_p2  <= 1'b0;
    end else begin
      rgb_p2 <= rgb_nx;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      bl_p2  <= bl_p1;
      sn_p2  <= hs_p1 ^ vs_p1;
    end
  end

  assign vga.vga_r      = rgb_p2[23:16];
  assign vga.vga_g      = rgb_p2[15:8];
  assign vga.vga_b      = rgb_p2[7:0];
  assign vga.h_sync_o   = hs_p2;
  assign vga.v_sync_o   = vs_p2;
  assign vga.blank_n_o  = bl_p2;
  assign vga.sync_n_o   = sn_p2;
  assign vga.cursor_row = row;
  assign vga.cursor_col = col;
  assign vga.marks      = marks;
endmodule
